// File: rtl/alu_pkg.sv
// Shared ALU definitions: CCR flag layout, per-op update masks and condition-code encodings.
package alu_pkg;

  localparam int unsigned C_BIT = 3;
  localparam int unsigned V_BIT = 2;
  localparam int unsigned N_BIT = 1;
  localparam int unsigned Z_BIT = 0;

  localparam logic [3:0] C_MASK = 4'b1000;
  localparam logic [3:0] V_MASK = 4'b0100;
  localparam logic [3:0] N_MASK = 4'b0010;
  localparam logic [3:0] Z_MASK = 4'b0001;

  // Logic ops leave carry/overflow alone; arithmetic ops update every flag.
  localparam logic [3:0] MASK_LOGIC = N_MASK | Z_MASK;
  localparam logic [3:0] MASK_ARITH = C_MASK | V_MASK | N_MASK | Z_MASK;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_NV = 4'd1,
    COND_EQ = 4'd2,
    COND_NE = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_CS = 4'd6,
    COND_CC = 4'd7,
    COND_VS = 4'd8,
    COND_VC = 4'd9,
    COND_HI = 4'd10,
    COND_LS = 4'd11,
    COND_GE = 4'd12,
    COND_LT = 4'd13,
    COND_GT = 4'd14,
    COND_LE = 4'd15
  } cond_e;

  function automatic logic [3:0] merge_ccr(input logic [3:0] ccr, input logic [3:0] flags,
                                           input logic [3:0] mask);
    return (ccr & ~mask) | (flags & mask);
  endfunction

endpackage

// File: rtl/ccr_cond_eval.sv
// Combinational branch-condition evaluation of a CCR value; shared with the sequencer.
module ccr_cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] ccr,
  input  logic [3:0] cond_sel,
  output logic       cond_true
);

  logic c, v, n, z;

  always_comb begin
    c = ccr[C_BIT];
    v = ccr[V_BIT];
    n = ccr[N_BIT];
    z = ccr[Z_BIT];
    cond_true = 1'b0;
    unique case (cond_e'(cond_sel))
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_MI: cond_true = n;
      COND_PL: cond_true = ~n;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = ~c & ~z;
      COND_LS: cond_true = c | z;
      COND_GE: cond_true = n ~^ v;
      COND_LT: cond_true = n ^ v;
      COND_GT: cond_true = ~z & (n ~^ v);
      COND_LE: cond_true = z | (n ^ v);
    endcase
  end

endmodule

// File: rtl/alu_ccr_writeback.sv
// ALU writeback stage: merges flags into the architectural CCR and queues {R, CCR} for the
// register file; also evaluates branch conditions against the committed CCR.
module alu_ccr_writeback
  import alu_pkg::*;
#(
  parameter int unsigned OP_SIZE = 4,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_SIZE-1:0] in_r,
  input  logic [3:0]         in_ccr,
  input  logic [3:0]         in_mask,
  input  logic               ccr_we,
  input  logic [3:0]         ccr_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_SIZE-1:0] out_r,
  output logic [3:0]         out_ccr,
  output logic [3:0]         ccr,
  input  logic [3:0]         cond_sel,
  output logic               cond_true
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [OP_SIZE-1:0] r_mem_q   [DEPTH];
  logic [3:0]         ccr_mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [3:0]         ccr_q, ccr_d;
  logic [3:0]         merged;
  logic               push, pop;

  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign merged    = merge_ccr(ccr_q, in_ccr, in_mask);

  // Head is forced to zero when empty so stale storage never shows on the outputs.
  assign out_r   = out_valid ? r_mem_q[rd_ptr_q] : '0;
  assign out_ccr = out_valid ? ccr_mem_q[rd_ptr_q] : '0;
  assign ccr     = ccr_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    // Direct load overrides the merge; the queued snapshot still carries the merge.
    ccr_d = ccr_q;
    if (ccr_we) begin
      ccr_d = ccr_wdata;
    end else if (push) begin
      ccr_d = merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ccr_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem_q[i]   <= '0;
        ccr_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ccr_q    <= ccr_d;
      if (push) begin
        r_mem_q[wr_ptr_q]   <= in_r;
        ccr_mem_q[wr_ptr_q] <= merged;
      end
    end
  end

  ccr_cond_eval u_cond_eval (
    .ccr       (ccr_q),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_alu_ccr_writeback.sv
// Self-checking bench for alu_ccr_writeback: queue-based reference model plus directed vectors.
module tb_alu_ccr_writeback;

  localparam int OP_SIZE = 4;
  localparam int DEPTH   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [OP_SIZE-1:0] in_r;
  logic [3:0]         in_ccr, in_mask;
  logic               ccr_we;
  logic [3:0]         ccr_wdata;
  logic               out_valid, out_ready;
  logic [OP_SIZE-1:0] out_r;
  logic [3:0]         out_ccr, ccr, cond_sel;
  logic               cond_true;

  int tests = 0;
  int fails = 0;

  // Reference model state: architectural flags and a queue of {R, flags} entries.
  logic [3:0]               m_ccr;
  logic [OP_SIZE+3:0]       m_q[$];

  alu_ccr_writeback #(.OP_SIZE(OP_SIZE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_ccr    (in_ccr),
    .in_mask   (in_mask),
    .ccr_we    (ccr_we),
    .ccr_wdata (ccr_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_ccr   (out_ccr),
    .ccr       (ccr),
    .cond_sel  (cond_sel),
    .cond_true (cond_true)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition truth from flag meanings: signed/unsigned comparison after a subtract.
  function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] sel);
    logic c, v, n, z, lt;
    c  = f[3];
    v  = f[2];
    n  = f[1];
    z  = f[0];
    lt = (n != v);
    case (sel)
      4'd0:  return 1'b1;
      4'd1:  return 1'b0;
      4'd2:  return z;
      4'd3:  return !z;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return c;
      4'd7:  return !c;
      4'd8:  return v;
      4'd9:  return !v;
      4'd10: return !c && !z;
      4'd11: return c || z;
      4'd12: return !lt;
      4'd13: return lt;
      4'd14: return !z && !lt;
      default: return z || lt;
    endcase
  endfunction

  initial begin
    logic [3:0] mrg;
    bit         do_push, do_pop;
    m_ccr = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_ccr = '0;
      end else begin
        do_push = in_valid && (m_q.size() < DEPTH);
        do_pop  = out_ready && (m_q.size() > 0);
        mrg = 4'b0;
        for (int b = 0; b < 4; b++) mrg[b] = in_mask[b] ? in_ccr[b] : m_ccr[b];
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back({in_r, mrg});
        if (ccr_we) m_ccr = ccr_wdata;
        else if (do_push) m_ccr = mrg;
      end
    end
  end

  // Every cycle, away from the clock edge, compare all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("m_out_valid", 8'(out_valid), 8'(m_q.size() != 0));
      check("m_in_ready", 8'(in_ready), 8'(m_q.size() != DEPTH));
      check("m_ccr", 8'(ccr), 8'(m_ccr));
      check("m_cond", 8'(cond_true), 8'(cond_ref(m_ccr, cond_sel)));
      if (m_q.size() != 0) begin
        check("m_out_r", 8'(out_r), 8'(m_q[0][OP_SIZE+3:4]));
        check("m_out_ccr", 8'(out_ccr), 8'(m_q[0][3:0]));
      end else begin
        check("m_out_r_idle", 8'(out_r), 8'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_r = '0; in_ccr = '0; in_mask = '0;
    ccr_we = 0; ccr_wdata = '0; out_ready = 0; cond_sel = '0;
    step(); step();
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", 8'(out_valid), 8'h0);
    check("rst_in_ready", 8'(in_ready), 8'h1);
    check("rst_ccr", 8'(ccr), 8'h0);
    check("rst_out_r", 8'(out_r), 8'h0);
    check("rst_out_ccr", 8'(out_ccr), 8'h0);
    step();

    // 1: logic-op push into empty FIFO
    in_valid = 1; in_r = 4'b1000; in_ccr = 4'b0010; in_mask = 4'b0011;
    step();
    in_valid = 0;
    check("t1_out_valid", 8'(out_valid), 8'h1);
    check("t1_out_r", 8'(out_r), 8'h8);
    check("t1_out_ccr", 8'(out_ccr), 8'h2);
    check("t1_ccr", 8'(ccr), 8'h2);
    cond_sel = 4'd4; #1 check("t1_mi", 8'(cond_true), 8'h1);
    cond_sel = 4'd2; #1 check("t1_eq", 8'(cond_true), 8'h0);
    out_ready = 1; step(); out_ready = 0;

    // 2: direct load, then AND keeps C and V
    ccr_we = 1; ccr_wdata = 4'b1100; step(); ccr_we = 0;
    in_valid = 1; in_r = 4'h5; in_ccr = 4'b0001; in_mask = 4'b0011; step(); in_valid = 0;
    check("t2_ccr", 8'(ccr), 8'hd);
    cond_sel = 4'd13; #1 check("t2_lt", 8'(cond_true), 8'h1);
    cond_sel = 4'd11; #1 check("t2_ls", 8'(cond_true), 8'h1);
    out_ready = 1; step(); out_ready = 0;

    // 3: fill to full, third push stalls until the first pop
    in_mask = 4'b1111; in_valid = 1;
    in_r = 4'h1; in_ccr = 4'b1000; step();
    in_r = 4'h2; in_ccr = 4'b0100; step();
    in_r = 4'h3; in_ccr = 4'b0010;
    check("t3_full", 8'(in_ready), 8'h0);
    step();
    check("t3_head_a", 8'(out_r), 8'h1);
    out_ready = 1; step();
    check("t3_head_b", 8'(out_r), 8'h2);
    check("t3_ready_again", 8'(in_ready), 8'h1);
    step(); in_valid = 0;
    check("t3_head_c", 8'(out_r), 8'h3);
    step();
    check("t3_drained", 8'(out_valid), 8'h0);
    out_ready = 0;

    // 4: steady push+pop at count 1 across pointer wraps
    in_valid = 1; in_r = 4'h0; in_mask = 4'b0011; step();
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_r = 4'(i); in_ccr = 4'(i * 3);
      cond_sel = 4'(i + 4);
      step();
      check("t4_head", 8'(out_r), 8'(i));
      check("t4_count1", 8'({out_valid, in_ready}), 8'h3);
    end
    in_valid = 0; step(); out_ready = 0;

    // 5: direct load beats the push for ccr, entry keeps the merge
    ccr_we = 1; ccr_wdata = 4'b0000;
    in_valid = 1; in_r = 4'h7; in_ccr = 4'b1111; in_mask = 4'b1111;
    step();
    ccr_we = 0; in_valid = 0;
    check("t5_ccr", 8'(ccr), 8'h0);
    check("t5_out_ccr", 8'(out_ccr), 8'hf);

    // 6: async reset while full
    in_valid = 1; in_r = 4'ha; in_ccr = 4'b1010; step(); in_valid = 0;
    check("t6_full", 8'(in_ready), 8'h0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_out_valid", 8'(out_valid), 8'h0);
    check("t6_rst_ccr", 8'(ccr), 8'h0);
    check("t6_rst_in_ready", 8'(in_ready), 8'h1);
    step();
    #2 rst = 1'b0;
    in_valid = 1; in_r = 4'h9; in_ccr = 4'b0001; in_mask = 4'b0011;
    step(); in_valid = 0;
    check("t6_head", 8'(out_r), 8'h9);
    check("t6_valid", 8'(out_valid), 8'h1);
    out_ready = 1; step(); out_ready = 0;

    // Sweep every condition over a few flag patterns
    for (int k = 0; k < 4; k++) begin
      ccr_we = 1; ccr_wdata = 4'(k * 5 + 2); step(); ccr_we = 0;
      for (int s = 0; s < 16; s++) begin
        cond_sel = 4'(s);
        #1 check("sweep_cond", 8'(cond_true), 8'(cond_ref(4'(k * 5 + 2), 4'(s))));
      end
    end
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
